// File: rtl/rgb_led_scheduler_if.sv
// rgb_led_scheduler_if
//   Bundles the requester-side inputs and the driver-side outputs of the
//   RGB LED scheduler.
//   master : status logic / testbench side (drives req, blink, color)
//   slave  : scheduler side (drives grant, busy and the LED driver controls)
//   Signals:
//     req    [N_REQ]            level request per requester (0 = highest priority)
//     blink  [N_REQ]            1 = requester wants its colour to blink
//     color  [N_REQ*3*PWM_BITS] slice i = {red,green,blue} duty of requester i
//     grant  [N_REQ]            one-hot current owner, 0 when none
//     busy                      scheduler not idle
//     rgb_en / cur_en           RGBLEDEN / CURREN of the RGB primitive
//     pwm_r / pwm_g / pwm_b     RGB2PWM / RGB0PWM / RGB1PWM
interface rgb_led_scheduler_if #(
  parameter int N_REQ    = 4,
  parameter int PWM_BITS = 8
);
  logic [N_REQ-1:0]            req;
  logic [N_REQ-1:0]            blink;
  logic [N_REQ*3*PWM_BITS-1:0] color;
  logic [N_REQ-1:0]            grant;
  logic                        busy;
  logic                        rgb_en;
  logic                        cur_en;
  logic                        pwm_r;
  logic                        pwm_g;
  logic                        pwm_b;

  modport master (
    output req, blink, color,
    input  grant, busy, rgb_en, cur_en, pwm_r, pwm_g, pwm_b
  );

  modport slave (
    input  req, blink, color,
    output grant, busy, rgb_en, cur_en, pwm_r, pwm_g, pwm_b
  );
endinterface

// File: rtl/rgb_led_scheduler.sv
// rgb_led_scheduler
//   Shares the single on-chip RGB LED driver among N_REQ status requesters.
//   Fixed priority (index 0 highest) with a minimum hold time before a
//   higher-priority requester may pre-empt the owner. Each requester supplies
//   a 3-channel duty and a blink flag. The driver is powered up (RGBLEDEN /
//   CURREN) PWRUP_CYC cycles before any PWM is produced and powered down for
//   one cycle after the last request goes away.
//   Ports:
//     int_osc  in  clock (HSOSC CLKHF)
//     rst      in  synchronous reset, active-high
//     bus      slave modport of rgb_led_scheduler_if (requests in, LED controls out)
//   All outputs come straight from flops.
module rgb_led_scheduler #(
  parameter int N_REQ     = 4,
  parameter int PWM_BITS  = 8,
  parameter int BLINK_DIV = 24000000,
  parameter int MIN_HOLD  = 4800000,
  parameter int PWRUP_CYC = 4800
) (
  input  logic               int_osc,
  input  logic               rst,
  rgb_led_scheduler_if.slave bus
);
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int HW = $clog2(MIN_HOLD + 1);
  localparam int PW = (PWRUP_CYC > 1) ? $clog2(PWRUP_CYC) : 1;
  localparam int CW = 3 * PWM_BITS;
  localparam logic [PWM_BITS-1:0] PWM_LAST   = PWM_BITS'((2 ** PWM_BITS) - 2);
  localparam logic [BW-1:0]       BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [HW-1:0]       HOLD_MAX   = HW'(MIN_HOLD);
  localparam logic [PW-1:0]       PWRUP_LAST = PW'(PWRUP_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_PWRUP, S_ACTIVE, S_PWRDN} state_t;

  state_t              r_state,     w_state_next;
  logic [PW-1:0]       r_pwr_cnt,   w_pwr_cnt_next;
  logic [PWM_BITS-1:0] r_pwm_cnt,   w_pwm_cnt_next;
  logic [BW-1:0]       r_blink_cnt, w_blink_cnt_next;
  logic                r_phase,     w_phase_next;
  logic [HW-1:0]       r_hold_cnt,  w_hold_cnt_next;
  logic [OW-1:0]       r_owner,     w_owner_next;
  logic [CW-1:0]       r_duty,      w_duty_next;
  logic                r_blink_lat, w_blink_lat_next;

  logic [N_REQ-1:0]    r_grant,  w_grant_next;
  logic                r_busy,   w_busy_next;
  logic                r_en,     w_en_next;
  logic                r_pwm_r,  w_pwm_r_next;
  logic                r_pwm_g,  w_pwm_g_next;
  logic                r_pwm_b,  w_pwm_b_next;

  logic [CW-1:0]       w_slice [N_REQ];
  logic [OW-1:0]       w_win;
  logic                w_any;
  logic                w_boundary;
  logic [HW-1:0]       w_hold_inc;
  logic                w_take;
  logic                w_latch;
  logic                w_on;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign w_slice[gi] = bus.color[gi*CW +: CW];
    end
  endgenerate

  // Lowest requesting index wins.
  always_comb begin
    w_win = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) w_win = OW'(i);
    end
  end

  assign w_any      = |bus.req;
  // The edge leaving the last count starts a new frame; all ownership and
  // colour decisions happen on that edge so the new frame already uses them.
  assign w_boundary = (r_pwm_cnt == PWM_LAST);
  // Hold time as it will stand in the new frame, saturating at MIN_HOLD.
  assign w_hold_inc = (r_hold_cnt == HOLD_MAX) ? r_hold_cnt : r_hold_cnt + 1'b1;

  // State register and datapath registers.
  always_ff @(posedge int_osc) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pwr_cnt   <= '0;
      r_pwm_cnt   <= '0;
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
      r_hold_cnt  <= '0;
      r_owner     <= '0;
      r_duty      <= '0;
      r_blink_lat <= 1'b0;
      r_grant     <= '0;
      r_busy      <= 1'b0;
      r_en        <= 1'b0;
      r_pwm_r     <= 1'b0;
      r_pwm_g     <= 1'b0;
      r_pwm_b     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_pwr_cnt   <= w_pwr_cnt_next;
      r_pwm_cnt   <= w_pwm_cnt_next;
      r_blink_cnt <= w_blink_cnt_next;
      r_phase     <= w_phase_next;
      r_hold_cnt  <= w_hold_cnt_next;
      r_owner     <= w_owner_next;
      r_duty      <= w_duty_next;
      r_blink_lat <= w_blink_lat_next;
      r_grant     <= w_grant_next;
      r_busy      <= w_busy_next;
      r_en        <= w_en_next;
      r_pwm_r     <= w_pwm_r_next;
      r_pwm_g     <= w_pwm_g_next;
      r_pwm_b     <= w_pwm_b_next;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    w_state_next     = r_state;
    w_pwr_cnt_next   = r_pwr_cnt;
    w_pwm_cnt_next   = r_pwm_cnt;
    w_blink_cnt_next = r_blink_cnt;
    w_phase_next     = r_phase;
    w_hold_cnt_next  = r_hold_cnt;
    w_owner_next     = r_owner;
    w_duty_next      = r_duty;
    w_blink_lat_next = r_blink_lat;
    w_take           = 1'b0;
    w_latch          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_next   = S_PWRUP;
          w_pwr_cnt_next = '0;
        end
      end
      S_PWRUP: begin
        if (r_pwr_cnt == PWRUP_LAST) begin
          if (w_any) begin
            w_state_next = S_ACTIVE;
            w_take       = 1'b1;
          end else begin
            w_state_next = S_PWRDN;
          end
        end else begin
          w_pwr_cnt_next = r_pwr_cnt + 1'b1;
        end
      end
      S_ACTIVE: begin
        w_pwm_cnt_next   = w_boundary ? '0 : r_pwm_cnt + 1'b1;
        w_hold_cnt_next  = w_hold_inc;
        w_blink_cnt_next = (r_blink_cnt == BLINK_LAST) ? '0 : r_blink_cnt + 1'b1;
        w_phase_next     = (r_blink_cnt == BLINK_LAST) ? ~r_phase : r_phase;
        if (w_boundary) begin
          if (!w_any) begin
            w_state_next = S_PWRDN;
          end else if (!bus.req[r_owner] ||
                       ((w_win < r_owner) && (w_hold_inc >= HOLD_MAX))) begin
            w_take = 1'b1;
          end else begin
            w_latch = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    // New owner: restart frame, hold time and blink in the ON phase.
    if (w_take) begin
      w_owner_next     = w_win;
      w_hold_cnt_next  = '0;
      w_pwm_cnt_next   = '0;
      w_blink_cnt_next = '0;
      w_phase_next     = 1'b1;
      w_latch          = 1'b1;
    end
    if (w_latch) begin
      w_duty_next      = w_slice[w_owner_next];
      w_blink_lat_next = bus.blink[w_owner_next];
    end
  end

  // Output values for the coming cycle, registered above.
  always_comb begin
    w_grant_next = '0;
    w_pwm_r_next = 1'b0;
    w_pwm_g_next = 1'b0;
    w_pwm_b_next = 1'b0;
    w_busy_next  = (w_state_next != S_IDLE);
    w_en_next    = (w_state_next == S_PWRUP) || (w_state_next == S_ACTIVE);
    w_on         = w_phase_next | ~w_blink_lat_next;
    if (w_state_next == S_ACTIVE) begin
      w_grant_next = N_REQ'(1) << w_owner_next;
      w_pwm_r_next = w_on & (w_pwm_cnt_next < w_duty_next[CW-1 -: PWM_BITS]);
      w_pwm_g_next = w_on & (w_pwm_cnt_next < w_duty_next[2*PWM_BITS-1 -: PWM_BITS]);
      w_pwm_b_next = w_on & (w_pwm_cnt_next < w_duty_next[PWM_BITS-1:0]);
    end
  end

  assign bus.grant  = r_grant;
  assign bus.busy   = r_busy;
  assign bus.rgb_en = r_en;
  assign bus.cur_en = r_en;
  assign bus.pwm_r  = r_pwm_r;
  assign bus.pwm_g  = r_pwm_g;
  assign bus.pwm_b  = r_pwm_b;
endmodule
